// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register and a single-outstanding imem port.
// Define FETCH_PERF_EN to add fetched-instruction and stall-cycle counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_stall,
   input  logic        io_redirect_valid,
   input  logic [31:0] io_redirect_pc,
   output logic        io_imem_req_valid,
   input  logic        io_imem_req_ready,
   output logic [31:0] io_imem_req_addr,
   input  logic        io_imem_resp_valid,
   input  logic [31:0] io_imem_resp_data,
   output logic [31:0] io_IF_ID_inst,
   output logic [31:0] io_IF_ID_pc,
`ifdef FETCH_PERF_EN
   output logic [31:0] io_perf_fetched,
   output logic [31:0] io_perf_stall_cycles,
`endif
   output logic        io_IF_ID_valid
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] ifid_inst_q, ifid_inst_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic        ifid_vld_q, ifid_vld_d;
   logic        deliver;
   logic [31:0] dinst;
   logic        hs;

   // Request is masked during reset so nothing is issued in the reset cycle.
   assign io_imem_req_valid = (state_q == S_REQ) && !reset;
   assign io_imem_req_addr  = pc_q;
   assign hs                = io_imem_req_valid && io_imem_req_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      buf_d   = buf_q;
      deliver = 1'b0;
      dinst   = buf_q;
      case (state_q)
         S_REQ: begin
            if (io_redirect_valid) begin
               pc_d = io_redirect_pc;
               // An accepted request this cycle belongs to the stale address.
               if (hs) state_d = S_DROP;
            end else if (hs) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (io_imem_resp_valid) begin
               if (io_redirect_valid) begin
                  pc_d    = io_redirect_pc;
                  state_d = S_REQ;
               end else if (io_stall) begin
                  buf_d   = io_imem_resp_data;
                  state_d = S_HOLD;
               end else begin
                  deliver = 1'b1;
                  dinst   = io_imem_resp_data;
                  pc_d    = pc_q + 32'd4;
                  state_d = S_REQ;
               end
            end else if (io_redirect_valid) begin
               pc_d    = io_redirect_pc;
               state_d = S_DROP;
            end
         end
         S_HOLD: begin
            if (io_redirect_valid) begin
               pc_d    = io_redirect_pc;
               state_d = S_REQ;
            end else if (!io_stall) begin
               deliver = 1'b1;
               pc_d    = pc_q + 32'd4;
               state_d = S_REQ;
            end
         end
         default: begin
            if (io_redirect_valid) pc_d = io_redirect_pc;
            if (io_imem_resp_valid) state_d = S_REQ;
         end
      endcase
   end

   always_comb begin
      ifid_inst_d = NOP_INST;
      ifid_pc_d   = 32'd0;
      ifid_vld_d  = 1'b0;
      if (!io_redirect_valid) begin
         if (io_stall) begin
            ifid_inst_d = ifid_inst_q;
            ifid_pc_d   = ifid_pc_q;
            ifid_vld_d  = ifid_vld_q;
         end else if (deliver) begin
            ifid_inst_d = dinst;
            ifid_pc_d   = pc_q;
            ifid_vld_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         buf_q       <= 32'd0;
         ifid_inst_q <= NOP_INST;
         ifid_pc_q   <= 32'd0;
         ifid_vld_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         buf_q       <= buf_d;
         ifid_inst_q <= ifid_inst_d;
         ifid_pc_q   <= ifid_pc_d;
         ifid_vld_q  <= ifid_vld_d;
      end
   end

   assign io_IF_ID_inst  = ifid_inst_q;
   assign io_IF_ID_pc    = ifid_pc_q;
   assign io_IF_ID_valid = ifid_vld_q;

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_q, stall_cnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         fetched_q   <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         if (deliver) fetched_q <= fetched_q + 32'd1;
         if (io_stall && !io_redirect_valid) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign io_perf_fetched      = fetched_q;
   assign io_perf_stall_cycles = stall_cnt_q;
`endif

endmodule
